// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Handles byte-lane steering, sign extension, misalignment rejection and a per-access watchdog.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_byte,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          dm_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  // Counter only has to reach TIMEOUT-1; the abort fires on the edge that would make it TIMEOUT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         state_r;
  logic           last_dm_r;
  logic           xfer_dm_r;
  logic           xfer_we_r;
  logic           xfer_byte_r;
  logic [1:0]     xfer_lane_r;
  logic [CW-1:0]  wd_cnt_r;

  logic           pick_dm_s;
  logic           misalign_s;
  logic           timeout_s;
  logic [31:0]    store_data_s;
  logic [31:0]    load_data_s;
  logic           unused_s;

  assign unused_s = ^if_addr[1:0];

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    case (lane)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] lane_sext(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {{24{b[7]}}, b};
  endfunction

  // Arbitration, alignment check, watchdog expiry and data steering.
  always_comb begin
    pick_dm_s    = 1'b0;
    misalign_s   = !dm_byte && (dm_addr[1:0] != 2'b00);
    timeout_s    = 1'b0;
    store_data_s = 32'h0000_0000;
    load_data_s  = mem_rdata;
    if (dm_req && !if_req) begin
      pick_dm_s = 1'b1;
    end else if (dm_req && if_req) begin
      pick_dm_s = !last_dm_r;
    end else begin
      pick_dm_s = 1'b0;
    end
    if (TIMEOUT != 0) begin
      timeout_s = (wd_cnt_r == CW'(TIMEOUT - 1));
    end else begin
      timeout_s = 1'b0;
    end
    if (dm_we) begin
      store_data_s = dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
    end else begin
      store_data_s = 32'h0000_0000;
    end
    if (xfer_byte_r) begin
      load_data_s = lane_sext(mem_rdata, xfer_lane_r);
    end else begin
      load_data_s = mem_rdata;
    end
  end

  // Control FSM with all outputs registered; pulse outputs default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      last_dm_r   <= 1'b1;
      xfer_dm_r   <= 1'b0;
      xfer_we_r   <= 1'b0;
      xfer_byte_r <= 1'b0;
      xfer_lane_r <= 2'b00;
      wd_cnt_r    <= '0;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_rdata    <= 32'h0000_0000;
      dm_gnt      <= 1'b0;
      dm_rvalid   <= 1'b0;
      dm_rdata    <= 32'h0000_0000;
      dm_err      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0000_0000;
      busy        <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_err    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (if_req || dm_req) begin
            if (pick_dm_s) begin
              last_dm_r <= 1'b1;
              dm_gnt    <= 1'b1;
              if (misalign_s) begin
                dm_err <= 1'b1;
              end else begin
                state_r     <= XFER;
                busy        <= 1'b1;
                mem_req     <= 1'b1;
                mem_we      <= dm_we;
                mem_be      <= dm_byte ? lane_be(dm_addr[1:0]) : 4'b1111;
                mem_addr    <= {dm_addr[AW-1:2], 2'b00};
                mem_wdata   <= store_data_s;
                xfer_dm_r   <= 1'b1;
                xfer_we_r   <= dm_we;
                xfer_byte_r <= dm_byte;
                xfer_lane_r <= dm_addr[1:0];
                wd_cnt_r    <= '0;
              end
            end else begin
              last_dm_r   <= 1'b0;
              if_gnt      <= 1'b1;
              state_r     <= XFER;
              busy        <= 1'b1;
              mem_req     <= 1'b1;
              mem_we      <= 1'b0;
              mem_be      <= 4'b1111;
              mem_addr    <= {if_addr[AW-1:2], 2'b00};
              mem_wdata   <= 32'h0000_0000;
              xfer_dm_r   <= 1'b0;
              xfer_we_r   <= 1'b0;
              xfer_byte_r <= 1'b0;
              xfer_lane_r <= 2'b00;
              wd_cnt_r    <= '0;
            end
          end
        end
        XFER: begin
          if (mem_ack) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            if (xfer_dm_r) begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= xfer_we_r ? 32'h0000_0000 : load_data_s;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else if (timeout_s) begin
            // Abandoned fetch still completes its handshake, with zero data and an error flag.
            state_r <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            dm_err  <= 1'b1;
            if (!xfer_dm_r) begin
              if_rvalid <= 1'b1;
              if_rdata  <= 32'h0000_0000;
            end
          end else begin
            wd_cnt_r <= wd_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage: lw/lb/sw/sb) of the multicycle CPU. It arbitrates round-robin, registers the winning request, drives a variable-latency ack handshake to memory, and performs byte-lane steering and sign extension for byte accesses. A per-transaction watchdog aborts accesses that never complete.

## Interface
- AW, 32, address width
- TIMEOUT, 64, max cycles waiting for mem_ack before abort; 0 disables watchdog
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (level)
- if_addr  in  AW  fetch word address
- if_gnt  out  1  one-cycle pulse: fetch accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request (level)
- dm_we  in  1  1 = store, 0 = load
- dm_byte  in  1  1 = byte access (lb/sb), 0 = word
- dm_addr  in  AW  byte address
- dm_wdata  in  32  store data (byte in [7:0] when dm_byte)
- dm_gnt  out  1  one-cycle pulse: data access accepted
- dm_rvalid  out  1  one-cycle pulse: access complete (load data valid / store done)
- dm_rdata  out  32  load result, sign-extended for byte loads
- dm_err  out  1  one-cycle pulse: misaligned word access or timeout
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completes current request this cycle
- mem_rdata  in  32  read word, valid when mem_ack
- busy  out  1  state != IDLE

## Operation
- States: IDLE, XFER. Reset: IDLE, last_gnt = DM (so IF wins first tie), all outputs 0, captured payload 0.
- IDLE: requests sampled only here. Winner: sole requester, else the one not in last_gnt. On edge: capture winner's payload, set last_gnt, go XFER, pulse gnt.
- Data misalignment (dm_byte=0, dm_addr[1:0]!=0) checked in IDLE: if DM wins, no memory access; dm_gnt and dm_err pulse next cycle together, state stays IDLE, last_gnt = DM.
- XFER: mem_req=1, mem_* driven from registers, stable until ack. req inputs ignored.
- mem_be: word = 4'b1111; byte = 4'b0001 << addr[1:0]. Byte store: wdata[7:0] replicated in all four lanes.
- On mem_ack edge: latch result, return IDLE, pulse rvalid next cycle. IF: if_rdata = mem_rdata. DM load: word = mem_rdata; byte = sign-extend lane addr[1:0]. DM store: dm_rdata = 0.
- Watchdog: counter clears on entry to XFER, increments each XFER cycle without ack; reaching TIMEOUT returns IDLE, drops mem_req, pulses dm_err (DM) or if_rvalid with if_rdata=0 plus dm_err (IF).
- rdata outputs hold last value between rvalid pulses.
- Requester obligations: hold req and payload stable until gnt; deassert req by the rvalid cycle unless a new access is wanted (req high in that IDLE cycle is a new request).

## Timing
- Cycle N: IDLE, req high. N+1: XFER, gnt pulse, mem_req high. Zero-wait ack at N+1 → rvalid at N+2, busy low at N+2.
- Throughput: one access per 2 cycles at zero wait; back-to-back requests alternate IF/DM.
- Ack latency k cycles after mem_req rise → rvalid at N+2+k.
- mem_ack while IDLE: ignored.
- Timeout: mem_req high for exactly TIMEOUT cycles, err pulse the cycle after.
- Reset assertion mid-XFER: mem_req, gnt, rvalid, err, busy drop immediately (asynchronously); no pulse emitted on release; first grant after release goes to IF.

## Test plan
- Single IF fetch, if_addr=0x100, ack same cycle mem_req rises, mem_rdata=0x3C010001 -> if_gnt at N+1, if_rvalid at N+2 with if_rdata=0x3C010001, mem_be=4'hF.
- if_req and dm_req held continuously, ack zero-wait -> grants alternate IF, DM, IF, DM; first grant IF after reset.
- Byte load dm_addr=0x203, mem_rdata=0x80FF7F01 -> mem_addr=0x200, mem_be=4'b1000, dm_rdata=0xFFFFFF80; same at addr 0x201 -> 0x0000007F.
- Byte store dm_addr=0x12, dm_wdata=0x000000AB, ack after 3 cycles -> mem_be=4'b0100, mem_wdata=0xABABABAB, dm_rvalid 5 cycles after request.
- Word load dm_addr=0x6 -> no mem_req, dm_gnt+dm_err pulse one cycle; then TIMEOUT=4 with no ack -> mem_req high 4 cycles, dm_err pulse, busy low.
- Reset pulled low during XFER with mem_ack withheld -> mem_req and busy fall same cycle; after release, if_req and dm_req both high -> IF granted.
